// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM states, default width, counter sizing.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter only needs to reach WIDTH-1; keep at least one bit for tiny widths.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell used as the per-bit adder of serial_adder.
module FullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic               w_s;
  logic               w_cout;

  FullAdder u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Start is honoured in IDLE and DONE only, so a request during RUN is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = (r_cnt == CNT_W'(WIDTH - 1));
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Sum bits enter at the MSB so after WIDTH steps bit 0 has reached the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= c_in;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_cout <= w_cout;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // On the last step r_carry is the carry into the MSB cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_step && w_last) begin
      r_ovf <= r_carry ^ w_cout;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);
  assign sum   = r_sum;
  assign c_out = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: random and directed additions checked against plain arithmetic.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: unsigned sum with carry, and signed overflow as an out-of-range signed result.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t e;
    longint u;
    longint sx;
    longint sy;
    longint st;
    u  = longint'(x) + longint'(y) + longint'(ci);
    sx = (x >= (1 << (W - 1))) ? longint'(x) - (longint'(1) << W) : longint'(x);
    sy = (y >= (1 << (W - 1))) ? longint'(y) - (longint'(1) << W) : longint'(y);
    st = sx + sy + longint'(ci);
    e.s  = u[W-1:0];
    e.co = u[W];
    e.ov = (st > ((longint'(1) << (W - 1)) - 1)) || (st < -(longint'(1) << (W - 1)));
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no result pending at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", 64'(sum), 64'(e.s));
        chk("c_out", 64'(c_out), 64'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", 64'(ovf), 64'(e.ov));
`endif
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input int inject_at);
    int cyc;
    int bcnt;
    start = 1'b1;
    a     = ta;
    b     = tb;
    c_in  = tc;
    q.push_back(model(ta, tb, tc));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    c_in  = 1'($urandom);
    cyc   = 0;
    bcnt  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (inject_at != 0 && cyc == inject_at) begin
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
      end else if (inject_at != 0 && cyc == inject_at + 1) begin
        start = 1'b0;
      end
    end while (!done && cyc < 4 * W);
    chk("latency", 64'(cyc), 64'(W + 1));
    chk("busy_cycles", 64'(bcnt), 64'(W));
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(c_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    run_op(8'h5A, 8'hA5, 1'b1, 0);
    @(negedge clk);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    repeat (2) @(negedge clk);
    chk("held_sum", 64'(sum), 64'h80);
    chk("held_done", 64'(done), 64'd0);

    // Start pulsed mid-run must not disturb the operation in flight.
    run_op(8'h01, 8'h02, 1'b0, 3);
    repeat (3) @(negedge clk);

    // Back-to-back: second start issued in the DONE cycle of the first.
    run_op(8'h33, 8'h44, 1'b0, 0);
    run_op(8'h10, 8'h20, 1'b0, 0);
    @(negedge clk);

    // Asynchronous reset in the middle of a run; no result may appear.
    start = 1'b1;
    a     = 8'hC3;
    b     = 8'h3C;
    c_in  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_cout", 64'(c_out), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("midrst_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    run_op(8'hC3, 8'h3C, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin an addition, sampled on rising clk.
REQ-005 SHALL have port a  input  WIDTH  first addend, captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  second addend, captured when start is accepted.
REQ-007 SHALL have port c_in  input  1  initial carry, captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-010 SHALL have port sum  output  WIDTH  result, a + b + c_in modulo 2^WIDTH.
REQ-011 SHALL have port c_out  output  1  final carry out of bit WIDTH-1.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 SHALL accept start in IDLE or DONE: load a and b into shift registers, carry register <= c_in, bit counter <= 0, state <= RUN.
REQ-014 SHALL in RUN, per cycle, add the operand LSBs and the carry register through one full-adder cell, shift the sum bit into sum from the MSB side, update the carry register with the cell carry, and increment the counter.
REQ-015 SHALL leave RUN after exactly WIDTH processing edges: state <= DONE, done <= 1, c_out <= final carry.
REQ-016 SHALL have latency WIDTH cycles: start sampled at edge T gives done high in the cycle after edge T+WIDTH.
REQ-017 SHALL drive busy high exactly while in RUN; done high exactly while in DONE (one cycle).
REQ-018 SHALL ignore start while in RUN; operands and progress are unaffected.
REQ-019 SHALL, in DONE without start, return to IDLE on the next edge; with start, go directly to RUN (back-to-back, no idle cycle).
REQ-020 SHALL hold sum and c_out stable from done until the next accepted start; values during RUN are unspecified intermediates.
REQ-021 SHALL treat a and b as unsigned for c_out; sum wraps modulo 2^WIDTH.

Reset
REQ-022 SHALL, on rst_n low at any time including mid-RUN, immediately clear state to IDLE, busy, done, sum, c_out, carry register, counter and shift registers to 0.
REQ-023 SHALL accept no start until the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with SERIAL_ADDER_OVF_EN defined, add output ovf (1 bit): carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, registered alongside c_out, reset 0, held like sum.
REQ-025 SHALL, without SERIAL_ADDER_OVF_EN, have no ovf port and no overflow logic.

Structure
REQ-026 SHALL place the FSM state enum and DEFAULT_WIDTH constant in shared package serial_adder_pkg.
REQ-027 SHALL instantiate the existing FullAdder cell exactly once as the per-bit adder; no other sub-modules.

Verification
REQ-028 WIDTH=8, start with a=0x5A, b=0xA5, c_in=1 -> done 8 cycles after start edge, sum=0x00, c_out=1, busy high for 8 cycles.
REQ-029 a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, ovf=0 (macro on); a=0x7F, b=0x01, c_in=0 -> sum=0x80, c_out=0, ovf=1.
REQ-030 start pulsed with a=0x11, b=0x22 at cycle 3 of RUN of a 0x01+0x02 operation -> result sum=0x03 unchanged, only one done pulse.
REQ-031 start asserted in the DONE cycle with a=0x10, b=0x20 -> done drops next cycle, busy high, second done 8 cycles later with sum=0x30; first sum held until that start.
REQ-032 rst_n pulsed low mid-RUN (cycle 4) -> all outputs 0 asynchronously, state IDLE, no done pulse; fresh start afterwards yields correct result.
